sc_code_decoder: RTL and testbench
==================================

SC_CODE_DECODER -- requirements
Module: sc_code_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of 2, at least 2).
REQ-002 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_data  input  8  sc_signal code to decode.
REQ-006 SHALL have port in_vld  input  1  in_data valid.
REQ-007 SHALL have port in_rd  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port out_data  output  32  decoded selector value.
REQ-009 SHALL have port out_dflt  output  1  code was the default code (0x04).
REQ-010 SHALL have port out_err  output  1  code is not producible by the encoder.
REQ-011 SHALL have port out_vld  output  1  out_* valid.
REQ-012 SHALL have port out_rd  input  1  consumer takes out_* this cycle.
REQ-013 SHALL have port clr_cnt  input  1  synchronous clear of both counters.
REQ-014 SHALL have port cnt_ok  output  CNT_W  accepted codes with out_err=0.
REQ-015 SHALL have port cnt_err  output  CNT_W  accepted codes with out_err=1.

Function
REQ-016 Transfer on a port SHALL occur only in a cycle where vld and rd are both 1.
REQ-017 Decode map SHALL be: 0x00 -> 0x00000001; 0x01 -> 0x00000002; 0x03 -> 0x00000003; 0x04 -> 0x00000000 with out_dflt=1; any other code -> 0x00000000 with out_err=1.
REQ-018 out_dflt and out_err SHALL never both be 1.
REQ-019 Each decoded word SHALL be written into a FIFO_DEPTH-entry FIFO on input transfer.
REQ-020 out_* SHALL be driven from the FIFO head; out_vld = FIFO not empty.
REQ-021 Latency SHALL be 1 cycle: a code accepted in cycle N is presented with out_vld=1 in cycle N+1 if the FIFO was empty.
REQ-022 in_rd SHALL equal FIFO not full; there is no bypass when full, even if out_rd=1.
REQ-023 Simultaneous push and pop when neither full nor empty SHALL leave occupancy unchanged and preserve order.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH; occupancy is tracked with one extra pointer bit.
REQ-025 Output order SHALL equal input acceptance order; no entry is dropped or duplicated.
REQ-026 out_data/flags SHALL be held stable while out_vld=1 and out_rd=0.
REQ-027 Each input transfer SHALL increment cnt_ok or cnt_err, chosen by the decoded out_err.
REQ-028 Counters SHALL saturate at all-ones and not wrap.
REQ-029 clr_cnt=1 SHALL zero both counters next cycle; a transfer in the same cycle is not counted.
REQ-030 The FIFO SHALL be unaffected by clr_cnt.

Reset
REQ-031 While rst_n=0 at a clock edge, the FIFO SHALL empty (pointers 0) and cnt_ok and cnt_err SHALL become 0.
REQ-032 During and after reset, out_vld=0 and in_rd=1 (once rst_n=1); out_data, out_dflt and out_err are don't-care while out_vld=0.
REQ-033 Reset asserted mid-stream SHALL discard all buffered entries, and no stale entry SHALL reappear after release.
REQ-034 Storage RAM SHALL need no reset.

Structure
REQ-035 A shared package SHALL hold the code constants (CODE_SEL1=0x00, CODE_SEL2=0x01, CODE_SEL3=0x03, CODE_DFLT=0x04) and the decoded-entry record (data 32, dflt 1, err 1).
REQ-036 The same package SHALL be used by the sc_signal encoder side.
REQ-037 The FIFO SHALL be a sub-module named sc_code_fifo, parameterised on depth and entry width (34).
REQ-038 The decode map SHALL be combinational logic ahead of the FIFO write port, inside sc_code_decoder.

Verification
REQ-039 Scenario: after reset, send 0x00, 0x01, 0x03, 0x04 back-to-back with out_rd=1 -> outputs 1, 2, 3, 0 (last with out_dflt=1), each 1 cycle after accept; cnt_ok=4.
REQ-040 Scenario: send 0x02 then 0xFF -> two outputs with data 0 and out_err=1; cnt_err=2, cnt_ok unchanged.
REQ-041 Scenario: hold out_rd=0 and send 5 codes -> in_rd drops after 4 accepts and the 5th waits; then out_rd=1 -> all 5 emerge in order with no loss.
REQ-042 Scenario: FIFO at 2 entries, simultaneous push/pop for 10 cycles -> occupancy stays 2; order preserved across pointer wrap.
REQ-043 Scenario: preload cnt_ok to all-ones through forced traffic (CNT_W=4, 20 valid codes) -> cnt_ok=0xF; then clr_cnt with a concurrent transfer -> cnt_ok=0 next cycle.
REQ-044 Scenario: 3 entries buffered, rst_n=0 for 1 cycle -> out_vld=0 next cycle, and after release no old entries appear.

Source files
------------

// File: rtl/sc_code_decoder_pkg.sv
// Shared sc_signal code definitions, used by both the encoder and the decoder.
package sc_code_decoder_pkg;

    localparam logic [7:0] CODE_SEL1 = 8'h00;
    localparam logic [7:0] CODE_SEL2 = 8'h01;
    localparam logic [7:0] CODE_SEL3 = 8'h03;
    localparam logic [7:0] CODE_DFLT = 8'h04;

    localparam int ENTRY_W = 34;

    typedef struct packed {
        logic [31:0] data;
        logic        dflt;
        logic        err;
    } sc_entry_t;

endpackage

// File: rtl/sc_code_decoder_fifo.sv
// Synchronous FIFO for decoded entries. Pointers carry one extra bit so
// full and empty can be told apart.
module sc_code_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 34
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_vld_i,
    output logic         wr_rdy_o,
    input  logic [W-1:0] wr_data_i,
    output logic         rd_vld_o,
    input  logic         rd_rdy_i,
    output logic [W-1:0] rd_data_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         full, empty, push, pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // No bypass: a full FIFO refuses writes even when a read happens this cycle.
    assign wr_rdy_o  = !full;
    assign rd_vld_o  = !empty;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    assign push = wr_vld_i && !full;
    assign pop  = rd_rdy_i && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/sc_code_decoder.sv
// Decodes sc_signal codes into selector words, buffers them in a FIFO and
// keeps saturating counts of good and bad codes.
module sc_code_decoder
    import sc_code_decoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_vld,
    output logic             in_rd,
    output logic [31:0]      out_data,
    output logic             out_dflt,
    output logic             out_err,
    output logic             out_vld,
    input  logic             out_rd,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_err
);

    sc_entry_t        dec_entry;
    sc_entry_t        head_entry;
    logic [ENTRY_W-1:0] fifo_rd_data;
    logic             in_xfer;
    logic [CNT_W-1:0] cnt_ok_q, cnt_ok_d;
    logic [CNT_W-1:0] cnt_err_q, cnt_err_d;

    always_comb begin
        dec_entry = '{data: 32'd0, dflt: 1'b0, err: 1'b0};
        case (in_data)
            CODE_SEL1: dec_entry.data = 32'd1;
            CODE_SEL2: dec_entry.data = 32'd2;
            CODE_SEL3: dec_entry.data = 32'd3;
            CODE_DFLT: dec_entry.dflt = 1'b1;
            default:   dec_entry.err  = 1'b1;
        endcase
    end

    sc_code_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_vld_i  (in_vld),
        .wr_rdy_o  (in_rd),
        .wr_data_i (dec_entry),
        .rd_vld_o  (out_vld),
        .rd_rdy_i  (out_rd),
        .rd_data_o (fifo_rd_data)
    );

    assign head_entry = sc_entry_t'(fifo_rd_data);
    assign out_data   = head_entry.data;
    assign out_dflt   = head_entry.dflt;
    assign out_err    = head_entry.err;

    assign in_xfer = in_vld && in_rd;

    // Clear wins over a same-cycle transfer, which is then not counted.
    always_comb begin
        cnt_ok_d  = cnt_ok_q;
        cnt_err_d = cnt_err_q;
        if (clr_cnt) begin
            cnt_ok_d  = '0;
            cnt_err_d = '0;
        end else if (in_xfer) begin
            if (dec_entry.err) begin
                if (cnt_err_q != '1) cnt_err_d = cnt_err_q + 1'b1;
            end else begin
                if (cnt_ok_q != '1) cnt_ok_d = cnt_ok_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_ok_q  <= '0;
            cnt_err_q <= '0;
        end else begin
            cnt_ok_q  <= cnt_ok_d;
            cnt_err_q <= cnt_err_d;
        end
    end

    assign cnt_ok  = cnt_ok_q;
    assign cnt_err = cnt_err_q;

endmodule

// File: tb/tb_sc_code_decoder.sv
// Bench for sc_code_decoder: directed scenarios plus random traffic checked
// against a queue-based reference model.
module tb_sc_code_decoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       in_data;
    logic             in_vld;
    logic             in_rd;
    logic [31:0]      out_data;
    logic             out_dflt;
    logic             out_err;
    logic             out_vld;
    logic             out_rd;
    logic             clr_cnt;
    logic [CNT_W-1:0] cnt_ok;
    logic [CNT_W-1:0] cnt_err;

    sc_code_decoder #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_vld   (in_vld),
        .in_rd    (in_rd),
        .out_data (out_data),
        .out_dflt (out_dflt),
        .out_err  (out_err),
        .out_vld  (out_vld),
        .out_rd   (out_rd),
        .clr_cnt  (clr_cnt),
        .cnt_ok   (cnt_ok),
        .cnt_err  (cnt_err)
    );

    always #5 clk = ~clk;

    // Reference model: expected entries {data, dflt, err} in acceptance order.
    logic [33:0]      exp_q[$];
    int               m_ok;
    int               m_err;
    int               vectors = 0;
    int               miscompares = 0;

    function automatic logic [33:0] ref_decode(input logic [7:0] code);
        case (code)
            8'h00:   return {32'd1, 1'b0, 1'b0};
            8'h01:   return {32'd2, 1'b0, 1'b0};
            8'h03:   return {32'd3, 1'b0, 1'b0};
            8'h04:   return {32'd0, 1'b1, 1'b0};
            default: return {32'd0, 1'b0, 1'b1};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        logic [33:0] head;
        chk("in_rd", 34'(in_rd), 34'(exp_q.size() < DEPTH));
        chk("out_vld", 34'(out_vld), 34'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            chk("out_data", 34'(out_data), 34'(head[33:2]));
            chk("out_dflt", 34'(out_dflt), 34'(head[1]));
            chk("out_err", 34'(out_err), 34'(head[0]));
        end
        chk("cnt_ok", 34'(cnt_ok), 34'(m_ok));
        chk("cnt_err", 34'(cnt_err), 34'(m_err));
    endtask

    // One clock: drive at the falling edge, check, advance the model, step.
    task automatic cycle(input logic rst, input logic vld, input logic [7:0] code,
                         input logic ord, input logic clr);
        logic [33:0] e;
        bit          acc;
        bit          pop;
        rst_n   = rst;
        in_vld  = vld;
        in_data = code;
        out_rd  = ord;
        clr_cnt = clr;
        check_state();
        if (!rst) begin
            exp_q.delete();
            m_ok  = 0;
            m_err = 0;
        end else begin
            acc = vld && (exp_q.size() < DEPTH);
            pop = ord && (exp_q.size() != 0);
            e   = ref_decode(code);
            if (pop) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(e);
            if (clr) begin
                m_ok  = 0;
                m_err = 0;
            end else if (acc) begin
                if (e[0]) m_err = (m_err == int'(CNT_MAX)) ? m_err : m_err + 1;
                else      m_ok  = (m_ok  == int'(CNT_MAX)) ? m_ok  : m_ok  + 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [7:0] rand_code();
        logic [7:0] tbl [5];
        tbl = '{8'h00, 8'h01, 8'h03, 8'h04, 8'h02};
        if ($urandom_range(0, 7) < 5) return tbl[$urandom_range(0, 4)];
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        logic [7:0] codes [5];
        rst_n = 1'b0; in_vld = 1'b0; in_data = 8'h00; out_rd = 1'b0; clr_cnt = 1'b0;
        m_ok = 0; m_err = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state, then the four legal codes back-to-back.
        check_state();
        cycle(1, 1, 8'h00, 1, 0);
        cycle(1, 1, 8'h01, 1, 0);
        cycle(1, 1, 8'h03, 1, 0);
        cycle(1, 1, 8'h04, 1, 0);
        cycle(1, 0, 8'h00, 1, 0);
        cycle(1, 0, 8'h00, 1, 0);

        // Illegal codes.
        cycle(1, 1, 8'h02, 1, 0);
        cycle(1, 1, 8'hFF, 1, 0);
        cycle(1, 0, 8'h00, 1, 0);
        cycle(1, 0, 8'h00, 1, 0);

        // Back-pressure: five codes against a stalled consumer.
        codes = '{8'h03, 8'h01, 8'h04, 8'h00, 8'h07};
        for (int i = 0; i < 4; i++) cycle(1, 1, codes[i], 0, 0);
        cycle(1, 1, codes[4], 0, 0);
        cycle(1, 1, codes[4], 0, 0);
        cycle(1, 1, codes[4], 1, 0);
        cycle(1, 1, codes[4], 1, 0);
        repeat (6) cycle(1, 0, 8'h00, 1, 0);

        // Steady occupancy of two across pointer wrap.
        cycle(1, 1, 8'h01, 0, 0);
        cycle(1, 1, 8'h03, 0, 0);
        repeat (10) cycle(1, 1, rand_code(), 1, 0);
        repeat (3) cycle(1, 0, 8'h00, 1, 0);

        // Counter saturation, then clear with a concurrent transfer.
        for (int i = 0; i < 20; i++) cycle(1, 1, (i % 2) ? 8'h01 : 8'h03, 1, 0);
        cycle(1, 1, 8'h00, 1, 1);
        cycle(1, 0, 8'h00, 1, 0);

        // Reset with three entries buffered.
        cycle(1, 1, 8'h00, 0, 0);
        cycle(1, 1, 8'h01, 0, 0);
        cycle(1, 1, 8'h03, 0, 0);
        cycle(0, 0, 8'h00, 0, 0);
        repeat (3) cycle(1, 0, 8'h00, 1, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 3) != 0),
                  rand_code(),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 39) == 0));
        end
        repeat (6) cycle(1, 0, 8'h00, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
